iq_correlator: RTL and testbench

//  Front-end I/Q correlator. Takes the 1-bit comparator sample stream `sig`,

---
 rtl/iq_correlator_pkg.sv | 21 ++
 rtl/iq_correlator_nco.sv | 38 +++
 rtl/iq_correlator.sv | 147 ++++++++++++++
 tb/tb_iq_correlator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/iq_correlator_pkg.sv
// Shared definitions for the I/Q correlator: FSM encoding, output
// saturation limits and the 8-bit saturating helper.
package iq_correlator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  // Clamp a signed value into the signed 8-bit output range.
  function automatic logic signed [7:0] sat8(input int x);
    if (x > SAT_MAX)      return 8'(SAT_MAX);
    else if (x < SAT_MIN) return 8'(SAT_MIN);
    else                  return 8'(x);
  endfunction

endpackage

// File: rtl/iq_correlator_nco.sv
// Square-wave quadrature NCO: phase accumulator advanced once per sample
// tick, with the top two phase bits decoded into +1/-1 LO signs.
module iq_nco
  import iq_correlator_pkg::*;
#(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               tick,
  input  logic [PHASE_W-1:0] freq,
  output logic               lo_i,   // 1 = +1, 0 = -1
  output logic               lo_q    // 1 = +1, 0 = -1
);

  logic [PHASE_W-1:0] phase;
  logic [1:0]         qd;

  // Phase accumulator: cleared while idle, wraps naturally modulo 2^PHASE_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + freq;
    end
  end

  // Quadrant decode: I is positive in quadrants 0 and 3, Q in 0 and 1.
  always_comb begin
    qd   = phase[PHASE_W-1:PHASE_W-2];
    lo_i = ~(qd[1] ^ qd[0]);
    lo_q = ~qd[1];
  end

endmodule

// File: rtl/iq_correlator.sv
// Front-end I/Q correlator: synchronises the 1-bit comparator stream, mixes
// it with a quadrature square-wave LO and integrates 2^LOG2N samples per
// arm, emitting a saturated signed 8-bit I/Q pair with a 1-clock strobe.
module iq_correlator
  import iq_correlator_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int DIV     = 4,
  parameter int LOG2N   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sig,
  input  logic [PHASE_W-1:0]  freq,
  output logic signed [7:0]   i_value,
  output logic signed [7:0]   q_value,
  output logic                rdy,
  output logic                busy
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ACC_W = LOG2N + 2;
  localparam int SHIFT = LOG2N - 7;

  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(DIV - 1);
  localparam logic signed [ACC_W-1:0] ACC_P1   = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_M1   = '1;

  state_t state, state_nxt;

  logic                    sig_meta, sig_s;
  logic                    sync_cnt;
  logic [DIV_W-1:0]        div;
  logic [LOG2N-1:0]        cnt;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] delta_i, delta_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic signed [ACC_W-1:0] scaled_i, scaled_q;
  logic                    lo_i, lo_q;
  logic                    clr, tick, block_end;

  assign busy      = (state != ST_IDLE);
  assign clr       = (state == ST_IDLE);
  assign tick      = (state == ST_RUN) && (div == DIV_LAST);
  assign block_end = tick && (cnt == '1);

  // Two-flop synchroniser for the asynchronous comparator bit.
  // NOTE: every clocked block uses non-blocking (<=) so flops all sample
  // pre-edge values; a blocking chain here would collapse into one flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_meta <= 1'b0;
      sig_s    <= 1'b0;
    end else begin
      sig_meta <= sig;
      sig_s    <= sig_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: IDLE -> SYNC (2 clocks) -> RUN, en low returns to IDLE.
  // NOTE: state_nxt is defaulted first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (en) state_nxt = ST_SYNC;
      ST_SYNC: begin
        if (!en)          state_nxt = ST_IDLE;
        else if (sync_cnt) state_nxt = ST_RUN;
      end
      ST_RUN:  if (!en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // SYNC dwell counter and sample-tick divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_cnt <= 1'b0;
      div      <= '0;
    end else begin
      sync_cnt <= (state == ST_SYNC) ? ~sync_cnt : 1'b0;
      if (state != ST_RUN) div <= '0;
      else if (tick)       div <= '0;
      else                 div <= div + DIV_W'(1);
    end
  end

  iq_nco #(.PHASE_W(PHASE_W)) u_nco (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick),
    .freq (freq),
    .lo_i (lo_i),
    .lo_q (lo_q)
  );

  // Mixer and integrator arithmetic: s*lo is +1 when the signs agree.
  always_comb begin
    delta_i  = (sig_s == lo_i) ? ACC_P1 : ACC_M1;
    delta_q  = (sig_s == lo_q) ? ACC_P1 : ACC_M1;
    sum_i    = acc_i + delta_i;
    sum_q    = acc_q + delta_q;
    scaled_i = sum_i >>> SHIFT;
    scaled_q = sum_q >>> SHIFT;
  end

  // Integrate per tick; on the last tick of a block, publish and restart
  // the block in the same edge so no sample is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_i   <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      i_value <= '0;
      q_value <= '0;
      rdy     <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (clr) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else if (block_end) begin
        i_value <= sat8(int'(scaled_i));
        q_value <= sat8(int'(scaled_q));
        rdy     <= 1'b1;
        acc_i   <= '0;
        acc_q   <= '0;
        cnt     <= '0;
      end else if (tick) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt + LOG2N'(1);
      end
    end
  end

endmodule

// File: tb/tb_iq_correlator.sv
// Directed self-checking bench for iq_correlator at default parameters.
module tb_iq_correlator;

  logic               clk;
  logic               rst;
  logic               en;
  logic               sig;
  logic [15:0]        freq;
  logic signed [7:0]  i_value;
  logic signed [7:0]  q_value;
  logic               rdy;
  logic               busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Sample sequence 1,1,0,0 (bit k is sample k).
  logic [3:0] pat = 4'b0011;

  iq_correlator #(.PHASE_W(16), .DIV(4), .LOG2N(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sig     (sig),
    .freq    (freq),
    .i_value (i_value),
    .q_value (q_value),
    .rdy     (rdy),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count falling edges until rdy is seen, bounded by limit.
  task automatic wait_rdy(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy && n < limit);
    if (!rdy) check("rdy_timeout", int'(rdy), 1);
  endtask

  // Drive nsamp samples of the 1,1,0,0 pattern, one per 4 clocks, counting rdy.
  task automatic drive_pattern(input int nsamp, output int seen);
    seen = 0;
    for (int k = 0; k < nsamp; k++) begin
      sig = pat[k % 4];
      repeat (4) begin
        @(negedge clk);
        if (rdy) seen++;
      end
    end
  endtask

  initial begin
    int n;
    int seen;
    rst  = 1'b0;
    en   = 1'b0;
    sig  = 1'b0;
    freq = 16'h0000;

    #2;
    check("reset_i", int'(i_value), 0);
    check("reset_q", int'(q_value), 0);
    check("reset_rdy", int'(rdy), 0);
    check("reset_busy", int'(busy), 0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Constant 1 at DC: full positive correlation, saturated to 127.
    sig = 1'b1;
    en  = 1'b1;
    wait_rdy(5000, n);
    check("first_rdy_latency", n, 4099);
    check("ones_i", int'(i_value), 127);
    check("ones_q", int'(q_value), 127);
    @(negedge clk);
    check("rdy_width", int'(rdy), 0);
    wait_rdy(5000, n);
    check("rdy_spacing", n + 1, 4096);
    check("ones_i_blk2", int'(i_value), 127);
    check("ones_q_blk2", int'(q_value), 127);

    // Constant 0 at DC: full negative correlation, -128 without clamping.
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    sig = 1'b0;
    en  = 1'b1;
    wait_rdy(5000, n);
    check("zeros_latency", n, 4099);
    check("zeros_i", int'(i_value), -128);
    check("zeros_q", int'(q_value), -128);

    // Quarter-rate LO with 1,1,0,0 input aligned to block start.
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    freq = 16'h4000;
    en   = 1'b1;
    repeat (2) @(negedge clk);
    drive_pattern(1024, seen);
    wait_rdy(100, n);
    check("quad_latency", n, 1);
    check("quad_i", int'(i_value), 0);
    check("quad_q", int'(q_value), 127);

    // Abort mid-block after 501 ticks: no strobe, outputs held.
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    drive_pattern(502, seen);
    en = 1'b0;
    seen = 0;
    repeat (2500) begin
      @(negedge clk);
      if (rdy) seen++;
    end
    check("abort_no_rdy", seen, 0);
    check("abort_hold_i", int'(i_value), 0);
    check("abort_hold_q", int'(q_value), 127);
    check("abort_busy", int'(busy), 0);

    // Restart: a full fresh block with phase back at 0.
    en = 1'b1;
    repeat (2) @(negedge clk);
    drive_pattern(1024, seen);
    check("restart_no_early_rdy", seen, 0);
    wait_rdy(100, n);
    check("restart_latency", n, 1);
    check("restart_i", int'(i_value), 0);
    check("restart_q", int'(q_value), 127);

    // Asynchronous reset between clock edges while running.
    en = 1'b0;
    @(negedge clk);
    freq = 16'h0000;
    sig  = 1'b1;
    en   = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_i", int'(i_value), 0);
    check("async_rst_q", int'(q_value), 0);
    check("async_rst_rdy", int'(rdy), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 1);
    wait_rdy(5000, n);
    check("post_rst_latency", n + 1, 4099);
    check("post_rst_i", int'(i_value), 127);
    check("post_rst_q", int'(q_value), 127);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
